// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default sizes,
// register address width and requester identifiers.
package rf_arb_pkg;

    localparam int N_DEF      = 32;
    localparam int NREQ_DEF   = 3;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        REQ_ALU    = 2'd0,
        REQ_LOAD   = 2'd1,
        REQ_MULDIV = 2'd2
    } req_id_e;

    // One-hot register select; x0 is hardwired and never tracked.
    function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        if (r == 5'd0) begin
            reg_onehot = 32'd0;
        end else begin
            reg_onehot = 32'd1 << r;
        end
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the requesters/issue stage and the register-file
// write arbiter; the arbiter attaches through the slave modport.
interface rf_write_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
);
    logic                       wb_hold;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*REG_ADDR_W-1:0] req_rd;
    logic [NREQ*N-1:0]          req_data;
    logic [REG_ADDR_W-1:0]      write_reg;
    logic [N-1:0]               write_data;
    logic                       regWrite;
    logic [1:0]                 grant_id;
    logic                       issue_valid;
    logic [REG_ADDR_W-1:0]      issue_rd;
    logic [31:0]                busy_mask;

    modport master (
        output wb_hold, req_valid, req_rd, req_data, issue_valid, issue_rd,
        input  req_ready, write_reg, write_data, regWrite, grant_id, busy_mask
    );

    modport slave (
        input  wb_hold, req_valid, req_rd, req_data, issue_valid, issue_rd,
        output req_ready, write_reg, write_data, regWrite, grant_id, busy_mask
    );
endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin picker: first valid requester at or after the pointer wins,
// wrapping from NREQ-1 back to 0. Purely combinational.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_grant_idx
);
    logic w_found;

    // Two passes: indices at/after the pointer, then the wrapped-around ones.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (i_valid[j] && (j >= int'(i_ptr)) && !w_found) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = PW'(j);
                w_found     = 1'b1;
            end else begin
                w_found     = w_found;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (i_valid[j] && (j < int'(i_ptr)) && !w_found) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = PW'(j);
                w_found     = 1'b1;
            end else begin
                w_found     = w_found;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file writeback arbiter: round-robin grant among NREQ requesters,
// one-cycle registered write port, optional pending-write scoreboard enabled
// by defining RF_WRITE_ARBITER_SCOREBOARD_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]         r_rr_ptr;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [N-1:0]          r_write_data;
    logic                  r_reg_write;
    logic [1:0]            r_grant_id;

    logic [NREQ-1:0]       w_valid;
    logic [NREQ-1:0]       w_grant;
    logic [PW-1:0]         w_gidx;
    logic [PW-1:0]         w_next_ptr;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [N-1:0]          w_sel_data;

    // Reset and hold both mask requests so ready is zero without any clock.
    assign w_valid = (rst && !bus.wb_hold) ? bus.req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .i_valid     (w_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    assign bus.req_ready = w_grant;
    assign w_xfer        = |w_grant;
    assign w_next_ptr    = (w_gidx == PW'(NREQ - 1)) ? '0 : (w_gidx + PW'(1));

    // AND-OR mux of the granted requester's rd/data (grant is one-hot).
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_sel_rd   = w_sel_rd   | ({REG_ADDR_W{w_grant[j]}} & bus.req_rd[j*REG_ADDR_W +: REG_ADDR_W]);
            w_sel_data = w_sel_data | ({N{w_grant[j]}} & bus.req_data[j*N +: N]);
        end
    end

    // Pointer, grant id and the registered register-file write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr     <= '0;
            r_grant_id   <= 2'd0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_xfer) begin
            r_rr_ptr   <= w_next_ptr;
            r_grant_id <= 2'(w_gidx);
            if (w_sel_rd != 5'd0) begin
                r_reg_write  <= 1'b1;
                r_write_reg  <= w_sel_rd;
                r_write_data <= w_sel_data;
            end else begin
                r_reg_write  <= 1'b0;
            end
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;
    assign bus.regWrite   = r_reg_write;
    assign bus.grant_id   = r_grant_id;

`ifdef RF_WRITE_ARBITER_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

    assign w_busy_set = bus.issue_valid ? reg_onehot(bus.issue_rd) : 32'd0;
    assign w_busy_clr = r_reg_write ? reg_onehot(r_write_reg) : 32'd0;

    // Set is applied after clear so a same-edge reissue keeps the bit busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
        end
    end

    assign bus.busy_mask = r_busy;
`else
    assign bus.busy_mask = 32'd0;
`endif

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter N, default 32, data width of register-file write data.
REQ-002 Parameter NREQ, default 3, number of writeback requesters (0=ALU, 1=LOAD, 2=MULDIV).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wb_hold  input  1  when 1, no grants issued.
REQ-006 req_valid  input  NREQ  per-requester write request.
REQ-007 req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
REQ-008 req_rd  input  NREQ*5  packed destination register, requester i at bits [5i+4:5i].
REQ-009 req_data  input  NREQ*N  packed write data, requester i at bits [N*i+N-1:N*i].
REQ-010 write_reg  output  5  register-file write address (registered).
REQ-011 write_data  output  N  register-file write data (registered).
REQ-012 regWrite  output  1  register-file write enable (registered).
REQ-013 grant_id  output  2  index of requester accepted in the previous cycle.
REQ-014 issue_valid  input  1  instruction issued with a destination register.
REQ-015 issue_rd  input  5  destination register of the issued instruction.
REQ-016 busy_mask  output  32  pending-write scoreboard, bit r = register r awaiting writeback.

Function
REQ-017 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i] at a rising edge.
REQ-018 req_ready SHALL be combinational from req_valid, rr_ptr and wb_hold; at most one bit high; all zero when wb_hold=1 or no valid.
REQ-019 Arbitration SHALL be round-robin: search starts at rr_ptr, wraps NREQ-1 -> 0; first valid requester wins.
REQ-020 After a transfer from requester i, rr_ptr SHALL become (i+1) mod NREQ; without a transfer rr_ptr holds.
REQ-021 Latency SHALL be one cycle: a transfer at edge k drives write_reg/write_data and regWrite=1 during cycle k+1.
REQ-022 regWrite SHALL be 1 for exactly one cycle per transfer and 0 in cycles following no transfer; back-to-back transfers give consecutive regWrite=1 cycles.
REQ-023 A transfer with rd=0 SHALL be accepted (ready, rr_ptr advances) but regWrite SHALL stay 0.
REQ-024 write_reg/write_data SHALL hold last value when regWrite=0.
REQ-025 grant_id SHALL update only on a transfer.
REQ-026 Scoreboard: at an edge with issue_valid=1 and issue_rd!=0, busy_mask[issue_rd] SHALL set.
REQ-027 At an edge where regWrite=1, busy_mask[write_reg] SHALL clear.
REQ-028 Simultaneous set and clear of the same register SHALL leave the bit set.
REQ-029 busy_mask[0] SHALL always be 0.
REQ-030 A requester whose valid drops without a grant SHALL lose nothing; no request state is stored in the block.

Reset
REQ-031 rst=0 SHALL immediately force regWrite=0, write_reg=0, write_data=0, grant_id=0, rr_ptr=0, busy_mask=0, regardless of clock.
REQ-032 req_ready SHALL be all zero while rst=0; a transfer in progress at reset assertion is discarded.
REQ-033 First grant after rst release SHALL favour requester 0.

Configuration
REQ-034 Macro RF_WRITE_ARBITER_SCOREBOARD_EN defined: busy_mask per REQ-026..029.
REQ-035 Macro undefined: no scoreboard flops, busy_mask tied to 0, issue_valid/issue_rd ignored; arbitration unchanged.

Structure
REQ-036 Package rf_arb_pkg SHALL hold NREQ default, REG_ADDR_W=5, requester ID constants (REQ_ALU, REQ_LOAD, REQ_MULDIV).
REQ-037 Sub-module rr_arbiter (NREQ-wide, valid in, one-hot grant out, pointer in) SHALL implement REQ-019; pointer register stays in rf_write_arbiter.

Verification
REQ-038 Reset release, req_valid=3'b111 held 4 cycles -> grants 0,1,2,0; regWrite=1 in cycles 2..5.
REQ-039 Only req 1 valid, rd=5, data=32'hDEADBEEF -> next cycle write_reg=5, write_data=32'hDEADBEEF, regWrite=1, grant_id=1.
REQ-040 req 0 valid with rd=0 -> ready=1, regWrite=0 next cycle, rr_ptr advances to 1.
REQ-041 wb_hold=1 with all valid -> req_ready=0, regWrite=0; release -> grant resumes at held rr_ptr.
REQ-042 issue_rd=7 then write to 7 while issuing 7 same edge -> busy_mask[7]=1; macro off -> busy_mask=0 throughout.
REQ-043 rst asserted mid-cycle with regWrite=1 -> regWrite and busy_mask clear without clock edge.
